// File: rtl/aidc_lite_block_buffer_if.sv
// Bundle of the concatenator-side inputs and the memory-write-side
// valid/ready output of the AIDC-Lite block buffer.
interface aidc_lite_block_buffer_if;
  logic         word_valid_i;
  logic [2:0]   word_addr_i;
  logic [63:0]  word_data_i;
  logic         done_i;
  logic         fail_i;
  logic         raw_valid_i;
  logic [511:0] raw_data_i;
  logic         valid_o;
  logic         ready_i;
  logic [511:0] data_o;
  logic         comp_o;
  logic [3:0]   len_o;
  logic         err_o;

  // Upstream/downstream environment drives the inputs, samples the outputs.
  modport master (
    output word_valid_i, word_addr_i, word_data_i, done_i, fail_i,
           raw_valid_i, raw_data_i, ready_i,
    input  valid_o, data_o, comp_o, len_o, err_o
  );

  // The block buffer itself.
  modport slave (
    input  word_valid_i, word_addr_i, word_data_i, done_i, fail_i,
           raw_valid_i, raw_data_i, ready_i,
    output valid_o, data_o, comp_o, len_o, err_o
  );
endinterface

// File: rtl/aidc_lite_block_buffer.sv
// AIDC-Lite block buffer: gathers up to eight 64-bit code words of one block
// into a 512-bit line and, at block completion, hands either that compressed
// line or the raw line to a one-deep output register with valid/ready.
module aidc_lite_block_buffer (
  input  logic                     clk,
  input  logic                     rst_n,
  aidc_lite_block_buffer_if.slave  bus
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [511:0] r_coll;
  logic [2:0]   r_hi;
  logic         r_any;
  logic [511:0] r_raw;
  logic         r_raw_ok;
  logic         r_done_d;
  logic [511:0] r_data;
  logic         r_comp;
  logic [3:0]   r_len;
  logic         r_err;

  logic [511:0] w_coll_wr;
  logic [2:0]   w_hi_wr;
  logic         w_c;
  logic [511:0] w_line;
  logic         w_comp;
  logic [3:0]   w_len;
  logic         w_load;
  logic         w_err_set;

  // Collect-buffer view with this cycle's word write merged in (addr 0 in MSBs).
  always_comb begin
    w_coll_wr = r_coll;
    w_hi_wr   = r_hi;
    if (bus.word_valid_i) begin
      for (int k = 0; k < 8; k++) begin
        if (bus.word_addr_i == k[2:0]) begin
          w_coll_wr[511 - 64*k -: 64] = bus.word_data_i;
        end else begin
          w_coll_wr[511 - 64*k -: 64] = r_coll[511 - 64*k -: 64];
        end
      end
      if (!r_any || (bus.word_addr_i > r_hi)) begin
        w_hi_wr = bus.word_addr_i;
      end else begin
        w_hi_wr = r_hi;
      end
    end else begin
      w_hi_wr = r_hi;
    end
  end

  // Completion event and the line it would emit (raw line on failure).
  always_comb begin
    w_c = bus.done_i & (bus.word_valid_i | ~r_done_d);
    if (bus.fail_i) begin
      w_line = r_raw;
      w_comp = 1'b0;
      w_len  = 4'd8;
    end else begin
      w_line = w_coll_wr;
      w_comp = 1'b1;
      w_len  = {1'b0, w_hi_wr} + 4'd1;
    end
  end

  // Output-register state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output-register next state: load, drain, or drop-with-error decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_err_set   = w_c & bus.fail_i & ~r_raw_ok;
    case (r_state)
      ST_EMPTY: begin
        if (w_c) begin
          w_state_nxt = ST_FULL;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (bus.ready_i && w_c) begin
          w_state_nxt = ST_FULL;
          w_load      = 1'b1;
        end else if (bus.ready_i) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_c) begin
          w_state_nxt = ST_FULL;
          w_err_set   = 1'b1;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Collect buffer, raw line capture and done delay; cleared on every completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_coll   <= 512'd0;
      r_hi     <= 3'd0;
      r_any    <= 1'b0;
      r_raw    <= 512'd0;
      r_raw_ok <= 1'b0;
      r_done_d <= 1'b1;
    end else begin
      r_done_d <= bus.done_i;
      if (bus.raw_valid_i) begin
        r_raw <= bus.raw_data_i;
      end else begin
        r_raw <= r_raw;
      end
      if (w_c) begin
        r_coll   <= 512'd0;
        r_hi     <= 3'd0;
        r_any    <= 1'b0;
        r_raw_ok <= bus.raw_valid_i;
      end else begin
        r_coll   <= w_coll_wr;
        r_hi     <= w_hi_wr;
        r_any    <= r_any | bus.word_valid_i;
        r_raw_ok <= r_raw_ok | bus.raw_valid_i;
      end
    end
  end

  // Output line register and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= 512'd0;
      r_comp <= 1'b0;
      r_len  <= 4'd0;
      r_err  <= 1'b0;
    end else begin
      if (w_load) begin
        r_data <= w_line;
        r_comp <= w_comp;
        r_len  <= w_len;
      end else begin
        r_data <= r_data;
        r_comp <= r_comp;
        r_len  <= r_len;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  assign bus.valid_o = (r_state == ST_FULL);
  assign bus.data_o  = r_data;
  assign bus.comp_o  = r_comp;
  assign bus.len_o   = r_len;
  assign bus.err_o   = r_err;

endmodule

// File: tb/tb_aidc_lite_block_buffer.sv
// Self-checking bench for aidc_lite_block_buffer: directed scenarios plus a
// randomized run against a block-level reference model.
module tb_aidc_lite_block_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aidc_lite_block_buffer_if bif ();

  aidc_lite_block_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (block level: word array, highest index, raw line).
  logic [63:0]  m_words [8];
  int           m_hi;
  logic [511:0] m_raw;
  bit           m_raw_ok;
  bit           m_done_d;
  bit           m_full;
  logic [511:0] m_data;
  logic         m_comp;
  logic [3:0]   m_len;
  bit           m_err;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_words[k] = 64'd0;
    m_hi = 0; m_raw = 512'd0; m_raw_ok = 0; m_done_d = 1;
    m_full = 0; m_data = 512'd0; m_comp = 1'b0; m_len = 4'd0; m_err = 0;
  endtask

  // One clock edge of the model, using the inputs currently applied.
  task automatic model_edge();
    logic [63:0]  w [8];
    int           hi;
    bit           c;
    logic [511:0] line;
    for (int k = 0; k < 8; k++) w[k] = m_words[k];
    hi = m_hi;
    if (bif.word_valid_i) begin
      w[bif.word_addr_i] = bif.word_data_i;
      if (int'(bif.word_addr_i) > hi) hi = int'(bif.word_addr_i);
    end
    c = bif.done_i && (bif.word_valid_i || !m_done_d);
    if (c) begin
      line = 512'd0;
      for (int k = 0; k < 8; k++) line[511 - 64*k -: 64] = w[k];
      if (m_full && !bif.ready_i) begin
        m_err = 1;
      end else begin
        m_full = 1;
        if (bif.fail_i) begin
          m_data = m_raw; m_comp = 1'b0; m_len = 4'd8;
        end else begin
          m_data = line; m_comp = 1'b1; m_len = 4'(hi + 1);
        end
      end
      if (bif.fail_i && !m_raw_ok) m_err = 1;
      for (int k = 0; k < 8; k++) m_words[k] = 64'd0;
      m_hi = 0;
      m_raw_ok = bif.raw_valid_i;
      if (bif.raw_valid_i) m_raw = bif.raw_data_i;
    end else begin
      if (m_full && bif.ready_i) m_full = 0;
      for (int k = 0; k < 8; k++) m_words[k] = w[k];
      m_hi = hi;
      if (bif.raw_valid_i) begin
        m_raw = bif.raw_data_i; m_raw_ok = 1;
      end
    end
    m_done_d = bif.done_i;
  endtask

  task automatic tick();
    if (!rst_n) model_reset(); else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.word_valid_i = 1'b0;
    bif.raw_valid_i  = 1'b0;
    bif.fail_i       = 1'b0;
  endtask

  task automatic put(input logic [2:0] a, input logic [63:0] d);
    bif.word_valid_i = 1'b1;
    bif.word_addr_i  = a;
    bif.word_data_i  = d;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    idle();
    bif.done_i = 1'b1; bif.ready_i = 1'b1;
    bif.word_addr_i = 3'd0; bif.word_data_i = 64'd0; bif.raw_data_i = 512'd0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bif.valid_o, bif.comp_o, bif.len_o, bif.err_o} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0", {bif.valid_o, bif.comp_o, bif.len_o, bif.err_o});
    end
    n_checks++;
    if (bif.data_o !== 512'd0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0", bif.data_o);
    end
  endtask

  task automatic test_compressed();
    logic [63:0] a, b, c;
    logic [511:0] r;
    a = rnd64(); b = rnd64(); c = rnd64(); r = rnd512();
    idle(); bif.done_i = 1'b0; bif.ready_i = 1'b1; tick();
    bif.raw_valid_i = 1'b1; bif.raw_data_i = r; tick();
    bif.raw_valid_i = 1'b0;
    put(3'd0, a); tick();
    put(3'd1, b); tick();
    put(3'd2, c); bif.done_i = 1'b1; tick();
    idle();
    n_checks++;
    if ({bif.valid_o, bif.comp_o, bif.len_o} !== {1'b1, 1'b1, 4'd3}) begin
      n_fail++; $display("FAIL comp_ctrl got=%b exp=%b", {bif.valid_o, bif.comp_o, bif.len_o}, {1'b1, 1'b1, 4'd3});
    end
    n_checks++;
    if (bif.data_o !== {a, b, c, 320'd0}) begin
      n_fail++; $display("FAIL comp_data got=%h exp=%h", bif.data_o, {a, b, c, 320'd0});
    end
    tick();
    n_checks++;
    if (bif.valid_o !== 1'b0) begin
      n_fail++; $display("FAIL comp_drain got=%b exp=0", bif.valid_o);
    end
  endtask

  task automatic test_failed();
    logic [511:0] r;
    r = rnd512();
    idle(); bif.done_i = 1'b0; tick();
    bif.raw_valid_i = 1'b1; bif.raw_data_i = r; tick();
    bif.raw_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      put(3'(k), rnd64()); tick();
    end
    put(3'd0, rnd64()); bif.done_i = 1'b1; bif.fail_i = 1'b1; tick();
    idle();
    n_checks++;
    if ({bif.valid_o, bif.comp_o, bif.len_o, bif.err_o} !== {1'b1, 1'b0, 4'd8, 1'b0}) begin
      n_fail++; $display("FAIL fail_ctrl got=%b exp=%b", {bif.valid_o, bif.comp_o, bif.len_o, bif.err_o}, {1'b1, 1'b0, 4'd8, 1'b0});
    end
    n_checks++;
    if (bif.data_o !== r) begin
      n_fail++; $display("FAIL fail_data got=%h exp=%h", bif.data_o, r);
    end
    tick();
  endtask

  task automatic test_tiny();
    logic [63:0] w;
    w = rnd64();
    idle(); bif.done_i = 1'b1; bif.ready_i = 1'b1;
    put(3'd0, w); tick();
    idle();
    n_checks++;
    if ({bif.valid_o, bif.comp_o, bif.len_o} !== {1'b1, 1'b1, 4'd1}) begin
      n_fail++; $display("FAIL tiny_ctrl got=%b exp=%b", {bif.valid_o, bif.comp_o, bif.len_o}, {1'b1, 1'b1, 4'd1});
    end
    n_checks++;
    if (bif.data_o !== {w, 448'd0}) begin
      n_fail++; $display("FAIL tiny_data got=%h exp=%h", bif.data_o, {w, 448'd0});
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [63:0] x, y0, y1, y2;
    logic [511:0] l1;
    x = rnd64(); y0 = rnd64(); y1 = rnd64(); y2 = rnd64();
    l1 = 512'd0; l1[319:256] = x;
    idle(); bif.done_i = 1'b1; bif.ready_i = 1'b0;
    put(3'd3, x); tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({bif.valid_o, bif.comp_o, bif.len_o, bif.data_o} !== {1'b1, 1'b1, 4'd4, l1}) begin
        n_fail++; $display("FAIL bp_stable cyc=%0d got v=%b c=%b l=%0d d=%h exp len=4 d=%h", i, bif.valid_o, bif.comp_o, bif.len_o, bif.data_o, l1);
      end
      idle();
      if (i == 0) bif.done_i = 1'b0;
      if (i == 2) put(3'd0, y0);
      if (i == 3) put(3'd1, y1);
      tick();
    end
    put(3'd2, y2); bif.done_i = 1'b1; bif.ready_i = 1'b1; tick();
    idle();
    n_checks++;
    if ({bif.valid_o, bif.comp_o, bif.len_o, bif.err_o} !== {1'b1, 1'b1, 4'd3, 1'b0}) begin
      n_fail++; $display("FAIL bp_b2b_ctrl got=%b exp=%b", {bif.valid_o, bif.comp_o, bif.len_o, bif.err_o}, {1'b1, 1'b1, 4'd3, 1'b0});
    end
    n_checks++;
    if (bif.data_o !== {y0, y1, y2, 320'd0}) begin
      n_fail++; $display("FAIL bp_b2b_data got=%h exp=%h", bif.data_o, {y0, y1, y2, 320'd0});
    end
    tick();
  endtask

  task automatic test_random();
    bit c_pred;
    for (int i = 0; i < 400; i++) begin
      idle();
      if ($urandom_range(5, 0) == 0) bif.done_i = ~bif.done_i;
      if ($urandom_range(2, 0) == 0) put(3'($urandom_range(7, 0)), rnd64());
      if ($urandom_range(7, 0) == 0) begin
        bif.raw_valid_i = 1'b1; bif.raw_data_i = rnd512();
      end
      bif.fail_i  = m_raw_ok && ($urandom_range(1, 0) == 1);
      bif.ready_i = ($urandom_range(3, 0) != 0);
      c_pred = bif.done_i && (bif.word_valid_i || !m_done_d);
      if (c_pred && m_full) bif.ready_i = 1'b1;
      tick();
      n_checks++;
      if ({bif.valid_o, bif.err_o} !== {m_full, m_err}) begin
        n_fail++; $display("FAIL rand_ve cyc=%0d got=%b exp=%b", i, {bif.valid_o, bif.err_o}, {m_full, m_err});
      end
      if (m_full) begin
        n_checks++;
        if ({bif.comp_o, bif.len_o, bif.data_o} !== {m_comp, m_len, m_data}) begin
          n_fail++; $display("FAIL rand_line cyc=%0d got c=%b l=%0d d=%h exp c=%b l=%0d d=%h", i, bif.comp_o, bif.len_o, bif.data_o, m_comp, m_len, m_data);
        end
      end
    end
    idle(); bif.ready_i = 1'b1; bif.done_i = 1'b1; tick(); tick();
  endtask

  task automatic test_overflow();
    logic [63:0] z;
    logic [511:0] l1;
    z = rnd64();
    l1 = 512'd0; l1[191:128] = z;
    idle(); bif.done_i = 1'b1; bif.ready_i = 1'b0; tick();
    put(3'd5, z); tick();
    idle(); bif.done_i = 1'b0; tick();
    put(3'd1, rnd64()); bif.done_i = 1'b1; tick();
    idle();
    n_checks++;
    if ({bif.valid_o, bif.len_o, bif.err_o, bif.data_o} !== {1'b1, 4'd6, 1'b1, l1}) begin
      n_fail++; $display("FAIL ovf_hold got v=%b l=%0d e=%b d=%h exp v=1 l=6 e=1 d=%h", bif.valid_o, bif.len_o, bif.err_o, bif.data_o, l1);
    end
    bif.ready_i = 1'b1; tick();
    n_checks++;
    if ({bif.valid_o, bif.err_o} !== 2'b01) begin
      n_fail++; $display("FAIL ovf_drop got=%b exp=01", {bif.valid_o, bif.err_o});
    end
    tick(); tick();
    n_checks++;
    if (bif.err_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky got=%b exp=1", bif.err_o);
    end
  endtask

  task automatic test_missing_raw();
    do_reset();
    bif.done_i = 1'b0; tick();
    put(3'd0, rnd64()); tick();
    put(3'd1, rnd64()); bif.done_i = 1'b1; bif.fail_i = 1'b1; tick();
    idle();
    n_checks++;
    if ({bif.valid_o, bif.comp_o, bif.len_o, bif.err_o} !== {1'b1, 1'b0, 4'd8, 1'b1}) begin
      n_fail++; $display("FAIL noraw_ctrl got=%b exp=%b", {bif.valid_o, bif.comp_o, bif.len_o, bif.err_o}, {1'b1, 1'b0, 4'd8, 1'b1});
    end
    n_checks++;
    if (bif.data_o !== 512'd0) begin
      n_fail++; $display("FAIL noraw_data got=%h exp=0", bif.data_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    idle(); bif.done_i = 1'b1; bif.ready_i = 1'b0;
    put(3'd2, rnd64()); tick();
    idle(); bif.done_i = 1'b0; put(3'd4, rnd64()); tick();
    idle(); rst_n = 1'b0; tick();
    n_checks++;
    if ({bif.valid_o, bif.comp_o, bif.len_o, bif.err_o, bif.data_o} !== 519'd0) begin
      n_fail++; $display("FAIL midrst got v=%b c=%b l=%0d e=%b d=%h exp all 0", bif.valid_o, bif.comp_o, bif.len_o, bif.err_o, bif.data_o);
    end
    rst_n = 1'b1; bif.done_i = 1'b1; bif.ready_i = 1'b1; tick(); tick();
    n_checks++;
    if ({bif.valid_o, bif.err_o} !== 2'b00) begin
      n_fail++; $display("FAIL midrst_after got=%b exp=00", {bif.valid_o, bif.err_o});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_compressed();
    test_failed();
    test_tiny();
    test_backpressure();
    test_random();
    test_overflow();
    test_missing_raw();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aidc_lite_block_buffer.md
# aidc_lite_block_buffer

Collects the 64-bit code words emitted by the AIDC-Lite code concatenator for one block into a 512-bit line. At block completion it emits either the compressed line or, on compression failure, the original raw 512-bit line. Sits directly downstream of the concatenator and feeds the memory-write path through a valid/ready handshake. Collection and output are ping-pong (collect buffer plus output register), so a block can be gathered while the previous one drains.

## Interface
- No parameters; widths fixed: 64-bit word, 8 words per line, 512-bit line.
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low; clock clk.
- word_valid_i  in  1  word write strobe from concatenator (no backpressure)
- word_addr_i  in  3  word index within block, 0..7
- word_data_i  in  64  code word
- done_i  in  1  concatenator done level (1 after reset and after each block end)
- fail_i  in  1  compression failed for the completing block (valid with done_i)
- raw_valid_i  in  1  strobe loading the uncompressed line of the current block
- raw_data_i  in  512  uncompressed line
- valid_o  out  1  output line valid
- ready_i  in  1  consumer accepts line when valid_o & ready_i
- data_o  out  512  output line
- comp_o  out  1  1 = compressed line, 0 = raw line
- len_o  out  4  64-bit beats to store, 1..8
- err_o  out  1  sticky error (overflow or missing raw); cleared only by reset

## Operation
- Collect buffer: 8 x 64 words, `hi_q[2:0]` (highest addr written), `any_q` (any word written), `raw_q[511:0]`, `raw_ok_q`, `done_d` (done_i delayed one cycle).
- Word write: on word_valid_i, word k stored at collect bits [511-64k -: 64] (addr 0 in MSBs). Overwriting an addr is allowed; `hi_q` = max addr seen. Writes are accepted regardless of done_i.
- Raw capture: raw_valid_i loads `raw_q` and sets `raw_ok_q`.
- Completion event C = done_i & (word_valid_i | ~done_d).
  - Covers the final word with done rising, a tiny block where done never falls, and a done edge without a word.
- On C, build the line including any same-cycle word write:
  - fail_i=0: data = collected words, unwritten words 0, comp=1, len = hi+1 (write this cycle included).
  - fail_i=1: data = `raw_q`, comp=0, len=8. Collected words are discarded. A same-cycle raw_valid_i belongs to the next block and is not used.
  - fail_i=1 with `raw_ok_q`=0: still emit `raw_q` contents, and set err_o.
- After C: collect words zeroed, `hi_q`=0, `any_q`=0, `raw_ok_q`=0 (unless raw_valid_i in the same cycle, which sets it). This clearing happens even when the block is dropped.
- Output register states:
  - EMPTY: valid_o=0. C -> FULL with the new line.
  - FULL: valid_o=1, outputs stable.
    - ready_i & ~C -> EMPTY.
    - ready_i & C -> FULL with the new line (back-to-back).
    - ~ready_i & C -> stay FULL, new line dropped, err_o=1.
- Writes after the 8th word on a failing block (addr wraps to 0) are harmless: the raw line is emitted.

## Timing
- Reset values:
  - valid_o=0, data_o=0, comp_o=0, len_o=0, err_o=0.
  - Collect buffer 0, `hi_q`=0, `any_q`=0, `raw_q`=0, `raw_ok_q`=0.
  - `done_d`=1, so the reset-high done_i is not an event.
- Latency: C in cycle T -> valid_o=1 with that line in T+1.
- Handshake: a line is consumed on the rising edge where valid_o & ready_i. The next line can appear the following cycle. Outputs must not change while valid_o & ~ready_i.
- err_o asserts the cycle after the offending C and holds until reset.
- Reset mid-operation: partially collected block and held output are discarded, and valid_o falls in the cycle after rst_n is sampled low.
- raw_valid_i for a block must arrive after the previous block's C cycle and strictly before its own C cycle.

## Test plan
- Compressed block:
  - Stimulus: raw_valid_i with line R; words addr0..2 = A,B,C; done_i rises with addr2 write; fail_i=0; ready_i=1.
  - Response: next cycle valid_o=1, comp_o=1, len_o=3, data_o = {A,B,C,320'b0}.
- Failed block:
  - Stimulus: raw R loaded; 8 words written, then addr0 rewritten as done_i rises; fail_i=1.
  - Response: data_o=R, comp_o=0, len_o=8, err_o=0.
- Tiny block, done_i stays 1:
  - Stimulus: single word W at addr0 with done_i=1 and done_d=1.
  - Response: valid_o, len_o=1, data_o[511:448]=W.
- Backpressure:
  - Stimulus: ready_i=0 for 10 cycles after the first line.
  - Response: outputs stable throughout.
  - Then: second block completes in the same cycle ready_i=1 -> second line presented the next cycle, no error.
- Overflow:
  - Stimulus: second C while FULL and ready_i=0.
  - Response: first line retained, second dropped, err_o=1 sticky.
- Missing raw:
  - Stimulus: fail_i=1 block with no raw_valid_i.
  - Response: err_o=1, line emitted with comp_o=0.
  - Then: reset mid-collection -> all outputs 0.
